// File: rtl/ntt_ctrl.sv
// Layer/butterfly sequencer for the in-place NTT: issues one (layer, bf) pair per
// cycle and drains the butterfly pipeline between layers before the next one reads.
module ntt_ctrl #(
    parameter int NUM_LAYERS = 9,
    parameter int NUM_BF     = 256,
    parameter int BF_LATENCY = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stall,
    output logic [3:0] layer_num,
    output logic [7:0] bf_num,
    output logic       issue_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int                   DRAIN_W    = $clog2(BF_LATENCY + 1);
    localparam logic [7:0]           BF_LAST    = 8'(NUM_BF - 1);
    localparam logic [3:0]           LAYER_LAST = 4'(NUM_LAYERS - 1);
    localparam logic [DRAIN_W-1:0]   DRAIN_LOAD = DRAIN_W'(BF_LATENCY);
    localparam logic [DRAIN_W-1:0]   DRAIN_ONE  = DRAIN_W'(1);

    state_t               state_q, state_d;
    logic [3:0]           layer_q, layer_d;
    logic [7:0]           bf_q, bf_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values; mixing in blocking assignments creates ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            layer_q <= '0;
            bf_q    <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            bf_q    <= bf_d;
            drain_q <= drain_d;
        end
    end

    // NOTE: every comb output gets a hold default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        bf_d    = bf_q;
        drain_d = drain_q;
        unique case (state_q)
            S_IDLE: begin
                layer_d = '0;
                bf_d    = '0;
                if (start) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (!stall) begin
                    if (bf_q == BF_LAST) begin
                        drain_d = DRAIN_LOAD;
                        state_d = S_DRAIN;
                    end else begin
                        bf_d = bf_q + 8'd1;
                    end
                end
            end
            S_DRAIN: begin
                drain_d = drain_q - DRAIN_ONE;
                // Leaving on the count-of-one cycle makes DRAIN last exactly BF_LATENCY cycles.
                if (drain_q == DRAIN_ONE) begin
                    if (layer_q == LAYER_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        layer_d = layer_q + 4'd1;
                        bf_d    = '0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                layer_d = '0;
                bf_d    = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue_valid = (state_q == S_ISSUE) && !stall;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
    end

    assign layer_num = layer_q;
    assign bf_num    = bf_q;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed bench for ntt_ctrl: default 9x256 configuration plus a 2x4, latency-1 corner.
module tb_ntt_ctrl;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic       start, stall;
    logic [3:0] layer_num;
    logic [7:0] bf_num;
    logic       issue_valid, busy, done;

    logic       start2, stall2;
    logic [3:0] layer_num2;
    logic [7:0] bf_num2;
    logic       issue_valid2, busy2, done2;

    int checks = 0;
    int errors = 0;

    ntt_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stall       (stall),
        .layer_num   (layer_num),
        .bf_num      (bf_num),
        .issue_valid (issue_valid),
        .busy        (busy),
        .done        (done)
    );

    ntt_ctrl #(.NUM_LAYERS(2), .NUM_BF(4), .BF_LATENCY(1)) dut_small (
        .clk         (clk),
        .rst         (rst),
        .start       (start2),
        .stall       (stall2),
        .layer_num   (layer_num2),
        .bf_num      (bf_num2),
        .issue_valid (issue_valid2),
        .busy        (busy2),
        .done        (done2)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One full transform on the default instance. Cycle k is the k-th cycle after
    // the edge that samples start; inputs change 1 ns after each rising edge and
    // outputs are sampled on the falling edge.
    task automatic run_full(input string tag, input int stall_a, input int stall_a_len,
                            input int stall_b, input int start_again, input int exp_done);
        int exp_layer = 0;
        int exp_bf    = 0;
        int issues    = 0;
        int dones     = 0;
        int done_cyc  = -1;
        int gap_run   = 0;
        @(posedge clk); #1;
        start = 1'b1;
        for (int k = 1; k <= exp_done + 3; k++) begin
            @(posedge clk); #1;
            start = (k == start_again);
            stall = (k >= stall_a && k < stall_a + stall_a_len) || (k == stall_b);
            @(negedge clk);
            if (k == 1) check({tag, "_busy_rise"}, 32'(busy), 32'd1);
            if (issue_valid) begin
                check({tag, "_layer"}, 32'(layer_num), 32'(exp_layer));
                check({tag, "_bf"}, 32'(bf_num), 32'(exp_bf));
                if (gap_run != 0) check({tag, "_gap"}, 32'(gap_run), 32'd6);
                gap_run = 0;
                issues++;
                if (exp_bf == 255) begin
                    exp_bf = 0;
                    exp_layer++;
                end else begin
                    exp_bf++;
                end
            end else if (busy && !stall && !done) begin
                gap_run++;
            end
            if (done) begin
                dones++;
                done_cyc = k;
                check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
                check({tag, "_last_gap"}, 32'(gap_run), 32'd6);
            end
            if (done_cyc > 0 && k == done_cyc + 1)
                check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        end
        start = 1'b0;
        stall = 1'b0;
        check({tag, "_issues"}, 32'(issues), 32'd2304);
        check({tag, "_done_count"}, 32'(dones), 32'd1);
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    endtask

    initial begin
        clk_en = 1'b0;
        rst    = 1'b0;
        start  = 1'b0;
        stall  = 1'b0;
        start2 = 1'b0;
        stall2 = 1'b0;

        // Asynchronous reset with the clock stopped.
        #3 rst = 1'b1;
        #1;
        check("rst_layer", 32'(layer_num), 32'd0);
        check("rst_bf", 32'(bf_num), 32'd0);
        check("rst_valid", 32'(issue_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_small_busy", 32'(busy2), 32'd0);
        #2 rst = 1'b0;
        clk_en = 1'b1;

        begin
            int active = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (busy || issue_valid || done || layer_num != 0 || bf_num != 0) active++;
            end
            check("idle_no_start", 32'(active), 32'd0);
        end

        // Full run, no stall.
        run_full("plain", 0, 0, 0, 0, 2359);

        // Stalls at (2,100) for 3 cycles and at (8,255) for 1 cycle.
        run_full("stall", 625, 3, 2355, 0, 2363);

        // Second start pulse during layer 4 is ignored.
        run_full("restart", 0, 0, 0, 1059, 2359);

        // Reset at layer 5, bf 37.
        begin
            int dones = 0;
            int active = 0;
            @(posedge clk); #1;
            start = 1'b1;
            for (int k = 1; k <= 1348; k++) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            check("abort_pos_layer", 32'(layer_num), 32'd5);
            check("abort_pos_bf", 32'(bf_num), 32'd37);
            rst = 1'b1;
            #1;
            check("abort_layer", 32'(layer_num), 32'd0);
            check("abort_bf", 32'(bf_num), 32'd0);
            check("abort_valid", 32'(issue_valid), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (done) dones++;
                if (busy || issue_valid) active++;
            end
            check("abort_no_done", 32'(dones), 32'd0);
            check("abort_stays_idle", 32'(active), 32'd0);
        end
        run_full("after_abort", 0, 0, 0, 0, 2359);

        // Corner: 2 layers x 4 butterflies, latency 1, start held high throughout.
        @(posedge clk); #1;
        start2 = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (k <= 11) begin
                automatic logic exp_v = (k <= 4) || (k >= 6 && k <= 9);
                check($sformatf("small_valid_c%0d", k), 32'(issue_valid2), 32'(exp_v));
                check($sformatf("small_done_c%0d", k), 32'(done2), 32'(k == 11));
                check($sformatf("small_busy_c%0d", k), 32'(busy2), 32'd1);
                if (exp_v) begin
                    check($sformatf("small_layer_c%0d", k), 32'(layer_num2), 32'(k >= 6));
                    check($sformatf("small_bf_c%0d", k), 32'(bf_num2), 32'((k <= 4) ? k - 1 : k - 6));
                end
            end else if (k == 12) begin
                check("small_idle_busy", 32'(busy2), 32'd0);
                check("small_idle_valid", 32'(issue_valid2), 32'd0);
            end else begin
                check("small_rerun_valid", 32'(issue_valid2), 32'd1);
                check("small_rerun_layer", 32'(layer_num2), 32'd0);
                check("small_rerun_bf", 32'(bf_num2), 32'd0);
            end
        end
        start2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
